// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the branch resolve stage.
// Op codes and RV32 branch funct3 values.
package branch_resolve_unit_pkg;

  localparam logic [1:0] OP_BRANCH = 2'b00;
  localparam logic [1:0] OP_JAL    = 2'b01;
  localparam logic [1:0] OP_JALR   = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_UND0 = 3'b010;
  localparam logic [2:0] F3_UND1 = 3'b011;

  typedef struct packed {
    logic br_en;
    logic illegal;
  } cond_t;

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// Combinational branch condition evaluator.
// Returns taken decision and illegal flag per op/funct3.
module branch_cond
  import branch_resolve_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   op,
  input  logic [2:0]   funct3,
  input  logic [W-1:0] lhs,
  input  logic [W-1:0] rhs,
  output logic         br_en,
  output logic         illegal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (lhs == rhs);
  assign lt_s = ($signed(lhs) < $signed(rhs));
  assign lt_u = (lhs < rhs);

  // Decode op, then the branch compare for conditional branches
  always_comb begin
    br_en   = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_BRANCH: begin
        case (funct3)
          F3_BEQ:  br_en = eq;
          F3_BNE:  br_en = ~eq;
          F3_BLT:  br_en = lt_s;
          F3_BGE:  br_en = ~lt_s;
          F3_BLTU: br_en = lt_u;
          F3_BGEU: br_en = ~lt_u;
          F3_UND0: illegal = 1'b1;
          F3_UND1: illegal = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL:  br_en = 1'b1;
      OP_JALR: br_en = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch/jump resolve stage with valid/ready
// handshake, mispredict detection and perf counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [2:0]       funct3,
  input  logic [W-1:0]     lhs,
  input  logic [W-1:0]     rhs,
  input  logic [W-1:0]     pc,
  input  logic [W-1:0]     imm,
  input  logic             pred_taken,
  input  logic [W-1:0]     pred_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             br_en,
  output logic [W-1:0]     target,
  output logic [W-1:0]     link,
  output logic             mispredict,
  output logic [W-1:0]     redirect_pc,
  output logic             illegal,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [W-1:0] FOUR = W'(4);
  localparam logic [W-1:0] LSB_MASK = ~W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic         accept;
  logic         fire;
  logic         c_br_en;
  logic         c_illegal;
  logic [W-1:0] c_pc_imm;
  logic [W-1:0] c_reg_imm;
  logic [W-1:0] c_target;
  logic [W-1:0] c_link;
  logic [W-1:0] c_redirect;
  logic         c_tgt_miss;
  logic         c_mispredict;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready & ~flush;
  assign fire     = out_valid & out_ready & ~flush;

  branch_cond #(
    .W (W)
  ) u_cond (
    .op      (op),
    .funct3  (funct3),
    .lhs     (lhs),
    .rhs     (rhs),
    .br_en   (c_br_en),
    .illegal (c_illegal)
  );

  assign c_pc_imm  = pc + imm;
  assign c_reg_imm = (lhs + imm) & LSB_MASK;
  assign c_link    = pc + FOUR;

  // Target select; JALR clears bit 0, others are pc-relative
  always_comb begin
    c_target = c_pc_imm;
    if (op == OP_JALR)
      c_target = c_reg_imm;
  end

  // Mispredict on direction error or wrong taken target
  always_comb begin
    c_tgt_miss   = c_br_en & pred_taken &
                   (c_target != pred_target);
    c_mispredict = (c_br_en != pred_taken) | c_tgt_miss;
    if (c_illegal)
      c_mispredict = 1'b0;
    c_redirect   = c_br_en ? c_target : c_link;
  end

  // Output valid tracks accept/handshake; flush dominates
  always_ff @(posedge clk) begin
    if (rst)
      out_valid <= 1'b0;
    else if (flush)
      out_valid <= 1'b0;
    else if (accept)
      out_valid <= 1'b1;
    else if (fire)
      out_valid <= 1'b0;
  end

  // Result registers load only when a bundle is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      br_en       <= 1'b0;
      target      <= '0;
      link        <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      illegal     <= 1'b0;
    end else if (accept) begin
      br_en       <= c_br_en;
      target      <= c_target;
      link        <= c_link;
      mispredict  <= c_mispredict;
      redirect_pc <= c_redirect;
      illegal     <= c_illegal;
    end
  end

  // Saturating perf counters bump on completed handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt   <= '0;
      mispred_cnt <= '0;
    end else if (fire) begin
      if (br_en && taken_cnt != CNT_MAX)
        taken_cnt <= taken_cnt + CNT_ONE;
      if (mispredict && mispred_cnt != CNT_MAX)
        mispred_cnt <= mispred_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: vector table, corner
// sequences and random traffic against a reference model.
module tb_branch_resolve_unit;

  localparam int W     = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  funct3;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred_taken;
    logic [31:0] pred_target;
  } bundle_t;

  typedef struct {
    logic        br;
    logic [31:0] target;
    logic [31:0] link;
    logic        mis;
    logic [31:0] redirect;
    logic        ill;
    logic        chk_t;
  } res_t;

  typedef struct {
    bundle_t     b;
    logic        br;
    logic [31:0] target;
    logic        mis;
    logic        ill;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [1:0]   op;
  logic [2:0]   funct3;
  logic [31:0]  lhs;
  logic [31:0]  rhs;
  logic [31:0]  pc;
  logic [31:0]  imm;
  logic         pred_taken;
  logic [31:0]  pred_target;
  logic         out_valid;
  logic         out_ready;
  logic         br_en;
  logic [31:0]  target;
  logic [31:0]  link;
  logic         mispredict;
  logic [31:0]  redirect_pc;
  logic         illegal;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  int checks = 0;
  int failures = 0;

  logic m_valid;
  res_t m_res;
  int   m_taken;
  int   m_mis;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .W     (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .op          (op),
    .funct3      (funct3),
    .lhs         (lhs),
    .rhs         (rhs),
    .pc          (pc),
    .imm         (imm),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .br_en       (br_en),
    .target      (target),
    .link        (link),
    .mispredict  (mispredict),
    .redirect_pc (redirect_pc),
    .illegal     (illegal),
    .taken_cnt   (taken_cnt),
    .mispred_cnt (mispred_cnt)
  );

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic res_t ref_resolve(bundle_t b);
    res_t r;
    r = '{default: '0};
    r.link = b.pc + 32'd4;
    case (b.op)
      2'd0: begin
        case (b.funct3)
          3'd0: r.br = (b.lhs == b.rhs);
          3'd1: r.br = (b.lhs != b.rhs);
          3'd4: r.br = ($signed(b.lhs) < $signed(b.rhs));
          3'd5: r.br = ($signed(b.lhs) >= $signed(b.rhs));
          3'd6: r.br = (b.lhs < b.rhs);
          3'd7: r.br = (b.lhs >= b.rhs);
          default: r.ill = 1'b1;
        endcase
      end
      2'd1: r.br = 1'b1;
      2'd2: r.br = 1'b1;
      default: r.ill = 1'b1;
    endcase
    if (b.op == 2'd2)
      r.target = (b.lhs + b.imm) & 32'hFFFF_FFFE;
    else
      r.target = b.pc + b.imm;
    r.chk_t = (b.op != 2'd3);
    if (r.ill)
      r.mis = 1'b0;
    else
      r.mis = (r.br != b.pred_taken) ||
              (r.br && b.pred_taken &&
               r.target != b.pred_target);
    r.redirect = r.br ? r.target : r.link;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_res   = '{default: '0};
    m_res.chk_t = 1'b1;
    m_taken = 0;
    m_mis   = 0;
  endtask

  task automatic check_outputs(string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".br_en"}, 32'(br_en), 32'(m_res.br));
    if (m_res.chk_t)
      chk({tag, ".target"}, target, m_res.target);
    chk({tag, ".link"}, link, m_res.link);
    chk({tag, ".mispredict"}, 32'(mispredict),
        32'(m_res.mis));
    chk({tag, ".redirect"}, redirect_pc, m_res.redirect);
    chk({tag, ".illegal"}, 32'(illegal), 32'(m_res.ill));
    chk({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(m_taken));
    chk({tag, ".mispred_cnt"}, 32'(mispred_cnt), 32'(m_mis));
  endtask

  // Drives one cycle starting just after a rising edge,
  // advances the model and checks just after the next edge.
  task automatic cycle(bundle_t b, logic iv, logic ordy,
                       logic fl, logic r, string tag);
    logic rdy_exp;
    logic acc;
    logic fire;
    in_valid    = iv;
    out_ready   = ordy;
    flush       = fl;
    rst         = r;
    op          = b.op;
    funct3      = b.funct3;
    lhs         = b.lhs;
    rhs         = b.rhs;
    pc          = b.pc;
    imm         = b.imm;
    pred_taken  = b.pred_taken;
    pred_target = b.pred_target;
    #1;
    rdy_exp = !m_valid || ordy;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy_exp));
    if (r) begin
      model_reset();
    end else begin
      acc  = iv && rdy_exp && !fl;
      fire = m_valid && ordy && !fl;
      if (fire) begin
        if (m_res.br && m_taken < CMAX) m_taken++;
        if (m_res.mis && m_mis < CMAX) m_mis++;
      end
      if (fl) m_valid = 1'b0;
      else if (acc) m_valid = 1'b1;
      else if (fire) m_valid = 1'b0;
      if (acc) m_res = ref_resolve(b);
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  function automatic bundle_t mk(logic [1:0] o,
      logic [2:0] f, logic [31:0] a, logic [31:0] bb,
      logic [31:0] p, logic [31:0] i, logic pt,
      logic [31:0] ptg);
    bundle_t x;
    x.op = o; x.funct3 = f; x.lhs = a; x.rhs = bb;
    x.pc = p; x.imm = i; x.pred_taken = pt;
    x.pred_target = ptg;
    return x;
  endfunction

  function automatic bundle_t rnd_bundle();
    bundle_t x;
    int sel;
    res_t r;
    sel = $urandom_range(0, 15);
    x.op = (sel < 10) ? 2'd0 : (sel < 12) ? 2'd1 :
           (sel < 15) ? 2'd2 : 2'd3;
    x.funct3 = 3'($urandom_range(0, 7));
    x.lhs = $urandom;
    x.rhs = ($urandom_range(0, 3) == 0) ? x.lhs : $urandom;
    if ($urandom_range(0, 3) == 0) x.rhs = {~x.lhs[31], x.lhs[30:0]};
    x.pc  = $urandom & 32'hFFFF_FFFC;
    x.imm = $urandom;
    x.pred_taken = 1'($urandom_range(0, 1));
    x.pred_target = $urandom;
    r = ref_resolve(x);
    if ($urandom_range(0, 1) == 1) x.pred_target = r.target;
    return x;
  endfunction

  vec_t    vecs[11];
  bundle_t idle;
  bundle_t jal;
  bundle_t hold_b;

  initial begin
    idle = mk(2'd0, 3'd0, 0, 0, 0, 0, 1'b0, 0);
    vecs[0]  = '{mk(0, 3'd0, 5, 5, 32'h100, 32'h20, 0, 0),
                 1, 32'h120, 1, 0};
    vecs[1]  = '{mk(0, 3'd4, 32'hFFFF_FFFF, 1, 32'h200, 8,
                    1, 32'h208), 1, 32'h208, 0, 0};
    vecs[2]  = '{mk(0, 3'd6, 32'hFFFF_FFFF, 1, 32'h200, 8,
                    0, 0), 0, 32'h208, 0, 0};
    vecs[3]  = '{mk(0, 3'd7, 32'h8000_0000, 32'h7FFF_FFFF,
                    0, 32'h40, 0, 0), 1, 32'h40, 1, 0};
    vecs[4]  = '{mk(2, 3'd0, 32'h1001, 0, 32'h300, 4,
                    1, 32'h1004), 1, 32'h1004, 0, 0};
    vecs[5]  = '{mk(2, 3'd0, 32'h1001, 0, 32'h300, 4,
                    1, 32'h1000), 1, 32'h1004, 1, 0};
    vecs[6]  = '{mk(0, 3'd2, 7, 7, 32'h10, 4, 1, 32'h14),
                 0, 32'h14, 0, 1};
    vecs[7]  = '{mk(3, 3'd0, 7, 7, 32'h20, 4, 1, 32'h24),
                 0, 32'h0, 0, 1};
    vecs[8]  = '{mk(1, 3'd0, 0, 0, 32'h400, 32'hFFFF_FFF0,
                    0, 0), 1, 32'h3F0, 1, 0};
    vecs[9]  = '{mk(0, 3'd1, 1, 2, 32'h500, 32'h10,
                    1, 32'h510), 1, 32'h510, 0, 0};
    vecs[10] = '{mk(0, 3'd5, 32'h8000_0000, 0, 32'h600, 8,
                    1, 32'h608), 0, 32'h608, 1, 0};

    model_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    flush = 1'b0;
    op = 0; funct3 = 0; lhs = 0; rhs = 0; pc = 0; imm = 0;
    pred_taken = 0; pred_target = 0;
    repeat (3) @(posedge clk);
    #1;
    cycle(idle, 1'b0, 1'b1, 1'b0, 1'b1, "reset");

    // Vector table, back-to-back with consumer ready
    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].b, 1'b1, 1'b1, 1'b0, 1'b0, "vec");
      chk($sformatf("vec%0d.br", i), 32'(br_en),
          32'(vecs[i].br));
      if (vecs[i].b.op != 2'd3)
        chk($sformatf("vec%0d.tgt", i), target,
            vecs[i].target);
      chk($sformatf("vec%0d.mis", i), 32'(mispredict),
          32'(vecs[i].mis));
      chk($sformatf("vec%0d.ill", i), 32'(illegal),
          32'(vecs[i].ill));
    end
    chk("vec0.redirect_first", 32'h120,
        ref_resolve(vecs[0].b).redirect);
    cycle(idle, 1'b0, 1'b1, 1'b0, 1'b0, "drain");
    chk("table.taken_cnt", 32'(taken_cnt), 32'd7);
    chk("table.mispred_cnt", 32'(mispred_cnt), 32'd5);

    // Backpressure: result held, no accept, no counting
    jal = mk(1, 3'd0, 0, 0, 32'h800, 32'h40, 1, 32'h840);
    cycle(jal, 1'b1, 1'b1, 1'b0, 1'b0, "bp_load");
    hold_b = mk(0, 3'd0, 3, 3, 32'h900, 32'h10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(hold_b, 1'b1, 1'b0, 1'b0, 1'b0, "bp_hold");
      chk("bp_hold.target_stable", target, 32'h840);
      chk("bp_hold.taken_cnt", 32'(taken_cnt), 32'd7);
    end
    cycle(hold_b, 1'b1, 1'b1, 1'b0, 1'b0, "bp_release");
    chk("bp_release.taken_cnt", 32'(taken_cnt), 32'd8);
    chk("bp_release.new_target", target, 32'h910);

    // Flush drops held result and same-cycle input
    cycle(jal, 1'b1, 1'b1, 1'b1, 1'b0, "flush");
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.taken_cnt", 32'(taken_cnt), 32'd8);
    cycle(idle, 1'b0, 1'b1, 1'b0, 1'b0, "post_flush");

    // Saturation: 17 taken results into a 4-bit counter
    cycle(idle, 1'b0, 1'b1, 1'b0, 1'b1, "sat_rst");
    for (int i = 0; i < 17; i++)
      cycle(jal, 1'b1, 1'b1, 1'b0, 1'b0, "sat");
    cycle(idle, 1'b0, 1'b1, 1'b0, 1'b0, "sat_drain");
    chk("sat.taken_cnt", 32'(taken_cnt), 32'd15);

    // Reset in the middle of traffic clears everything
    cycle(jal, 1'b1, 1'b1, 1'b0, 1'b0, "pre_rst");
    cycle(jal, 1'b1, 1'b1, 1'b1, 1'b1, "mid_rst");
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.target", target, 32'd0);
    chk("mid_rst.link", link, 32'd0);
    chk("mid_rst.taken_cnt", 32'(taken_cnt), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic iv;
      logic ordy;
      logic fl;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      cycle(rnd_bundle(), iv, ordy, fl,
            ($urandom_range(0, 149) == 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
